add_rs: RTL

- Reservation station for the add/sub functional unit in the Tomasulo core, directly upstream of the add/sub ALU.
- Accepts issued instructions whose operands are values or producer tags, and snoops the common data bus (CDB) to resolve pending tags.
- When the ALU signals it can take work, it dispatches the oldest entry whose operands are both valid.

---
 rtl/add_rs_if.sv | 35 +++
 rtl/add_rs.sv | 111 +++++++++++
 2 files changed

// File: rtl/add_rs_if.sv
// Issue, CDB-snoop and ALU-dispatch signals of the add/sub reservation station.
interface add_rs_if #(
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned DATA_W = 32
);
  logic              issue_valid;
  logic              issue_op;
  logic [DATA_W-1:0] issue_Vj;
  logic [TAG_W-1:0]  issue_Qj;
  logic [DATA_W-1:0] issue_Vk;
  logic [TAG_W-1:0]  issue_Qk;
  logic              issue_ready;
  logic [TAG_W-1:0]  issue_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              alu_available;
  logic              alu_EN;
  logic [DATA_W-1:0] alu_data1;
  logic [DATA_W-1:0] alu_data2;
  logic              alu_op;
  logic [TAG_W-1:0]  alu_tag;

  modport master (
    output issue_valid, issue_op, issue_Vj, issue_Qj, issue_Vk, issue_Qk,
    output cdb_valid, cdb_tag, cdb_data, alu_available,
    input  issue_ready, issue_tag, alu_EN, alu_data1, alu_data2, alu_op, alu_tag
  );

  modport slave (
    input  issue_valid, issue_op, issue_Vj, issue_Qj, issue_Vk, issue_Qk,
    input  cdb_valid, cdb_tag, cdb_data, alu_available,
    output issue_ready, issue_tag, alu_EN, alu_data1, alu_data2, alu_op, alu_tag
  );
endinterface

// File: rtl/add_rs.sv
// Add/sub reservation station: tag-based operand capture from the CDB and
// oldest-ready-first dispatch to the ALU.
module add_rs #(
  parameter int unsigned NUM_ENTRIES = 3,
  parameter int unsigned TAG_W       = 4,
  parameter int unsigned TAG_BASE    = 1,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned AGE_W       = 3
) (
  input  logic     clk,
  input  logic     nRST,
  add_rs_if.slave  rs
);

  localparam int unsigned IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  typedef struct packed {
    logic              busy;
    logic              op;
    logic [DATA_W-1:0] vj;
    logic [TAG_W-1:0]  qj;
    logic [DATA_W-1:0] vk;
    logic [TAG_W-1:0]  qk;
    logic [AGE_W-1:0]  age;
  } entry_t;

  entry_t ent_q [NUM_ENTRIES];
  entry_t ent_d [NUM_ENTRIES];

  logic              free_found;
  logic [IDX_W-1:0]  free_idx;
  logic              disp_found;
  logic [IDX_W-1:0]  disp_idx;
  logic [AGE_W-1:0]  best_age;
  logic              disp_en;
  logic              issue_acc;
  logic              fwd_j;
  logic              fwd_k;

  // State register
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) ent_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) ent_q[i] <= ent_d[i];
    end
  end

  // Free-slot and dispatch selection plus all station outputs, from registered state
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    disp_found = 1'b0;
    disp_idx   = '0;
    best_age   = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (!ent_q[i].busy && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      // Strictly-greater keeps the lowest index on equal (incl. saturated) ages
      if (ent_q[i].busy && ent_q[i].qj == '0 && ent_q[i].qk == '0 &&
          (!disp_found || ent_q[i].age > best_age)) begin
        disp_found = 1'b1;
        disp_idx   = IDX_W'(i);
        best_age   = ent_q[i].age;
      end
    end
    disp_en        = disp_found && rs.alu_available;
    rs.issue_ready = free_found;
    rs.issue_tag   = free_found ? TAG_W'(TAG_BASE + 32'(free_idx)) : '0;
    rs.alu_EN      = disp_en;
    rs.alu_data1   = disp_en ? ent_q[disp_idx].vj : '0;
    rs.alu_data2   = disp_en ? ent_q[disp_idx].vk : '0;
    rs.alu_op      = disp_en ? ent_q[disp_idx].op : 1'b0;
    rs.alu_tag     = disp_en ? TAG_W'(TAG_BASE + 32'(disp_idx)) : '0;
  end

  // Next state: aging, CDB snoop, dispatch release and issue allocation
  always_comb begin
    issue_acc = rs.issue_valid && free_found;
    fwd_j     = rs.cdb_valid && rs.issue_Qj != '0 && rs.issue_Qj == rs.cdb_tag;
    fwd_k     = rs.cdb_valid && rs.issue_Qk != '0 && rs.issue_Qk == rs.cdb_tag;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].busy) begin
        if (ent_q[i].age != AGE_MAX) ent_d[i].age = ent_q[i].age + AGE_W'(1);
        if (rs.cdb_valid && ent_q[i].qj != '0 && ent_q[i].qj == rs.cdb_tag) begin
          ent_d[i].vj = rs.cdb_data;
          ent_d[i].qj = '0;
        end
        if (rs.cdb_valid && ent_q[i].qk != '0 && ent_q[i].qk == rs.cdb_tag) begin
          ent_d[i].vk = rs.cdb_data;
          ent_d[i].qk = '0;
        end
        if (disp_en && disp_idx == IDX_W'(i)) ent_d[i].busy = 1'b0;
      end
      if (issue_acc && free_idx == IDX_W'(i)) begin
        ent_d[i].busy = 1'b1;
        ent_d[i].op   = rs.issue_op;
        ent_d[i].vj   = fwd_j ? rs.cdb_data : rs.issue_Vj;
        ent_d[i].qj   = fwd_j ? '0 : rs.issue_Qj;
        ent_d[i].vk   = fwd_k ? rs.cdb_data : rs.issue_Vk;
        ent_d[i].qk   = fwd_k ? '0 : rs.issue_Qk;
        ent_d[i].age  = '0;
      end
    end
  end

endmodule
